// File: rtl/ones_run_tx.sv
// Serial stimulus transmitter: a gap of zeros, a run of ones, then one terminating zero.
// Alongside the stream, expect_y predicts a Moore three-ones detector fed x_out on the same clock.
module ones_run_tx #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] run_len,
    input  logic [CNT_W-1:0] gap_len,
    output logic             busy,
    output logic             done,
    output logic             x_out,
    output logic             expect_y
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        RUN  = 2'd2,
        TAIL = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Handshake: start is accepted only on an edge where the FSM is IDLE (busy=0);
    // any start seen while busy is dropped, never queued.
    state_t           state, next_state;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] run_q, run_q_next;
    logic [1:0]       ones_cnt, ones_next;
    logic             busy_next, done_next, x_next, y_next;

    // State register, counters and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            run_q    <= '0;
            ones_cnt <= 2'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            x_out    <= 1'b0;
            expect_y <= 1'b0;
        end else begin
            state    <= next_state;
            cnt      <= cnt_next;
            run_q    <= run_q_next;
            ones_cnt <= ones_next;
            busy     <= busy_next;
            done     <= done_next;
            x_out    <= x_next;
            expect_y <= y_next;
        end
    end

    // cnt holds the cycles remaining in GAP/RUN after the current one
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        run_q_next = run_q;
        case (state)
            IDLE: begin
                if (start) begin
                    run_q_next = run_len;
                    if (gap_len != '0) begin
                        next_state = GAP;
                        cnt_next   = gap_len - ONE;
                    end else if (run_len != '0) begin
                        next_state = RUN;
                        cnt_next   = run_len - ONE;
                    end else begin
                        next_state = TAIL;
                        cnt_next   = '0;
                    end
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    if (run_q != '0) begin
                        next_state = RUN;
                        cnt_next   = run_q - ONE;
                    end else begin
                        next_state = TAIL;
                    end
                end else begin
                    cnt_next = cnt - ONE;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    next_state = TAIL;
                end else begin
                    cnt_next = cnt - ONE;
                end
            end
            TAIL: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Outputs are registered from next_state so they line up with the state they describe
    always_comb begin
        x_next    = (next_state == RUN);
        busy_next = (next_state != IDLE);
        done_next = (state == TAIL);
        if (x_out) begin
            ones_next = (ones_cnt == 2'd3) ? 2'd3 : ones_cnt + 2'd1;
        end else begin
            ones_next = 2'd0;
        end
        y_next = (ones_next == 2'd3);
    end

endmodule

// File: tb/tb_ones_run_tx.sv
// Self-checking bench for ones_run_tx: directed scenarios plus randomized sequences,
// checked cycle by cycle against a stream-level reference model.
module tb_ones_run_tx;

    logic       clock;
    logic       reset;
    logic       start;
    logic [3:0] run_len;
    logic [3:0] gap_len;
    logic       busy;
    logic       done;
    logic       x_out;
    logic       expect_y;

    int n_checks = 0;
    int n_fail   = 0;
    int hist     = 0;  // consecutive ones seen on the modelled stream so far

    ones_run_tx #(.CNT_W(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .run_len  (run_len),
        .gap_len  (gap_len),
        .busy     (busy),
        .done     (done),
        .x_out    (x_out),
        .expect_y (expect_y)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic launch(input int g, input int r);
        @(negedge clock);
        gap_len = 4'(g);
        run_len = 4'(r);
        start   = 1'b1;
    endtask

    // Follows one accepted sequence through its done cycle; optionally chains the next start.
    task automatic do_seq(input int g, input int r, input bit toggle, input bit chain,
                          input int ng, input int nr, input string tag);
        int         ycnt;
        int         exp_ycnt;
        logic       ex;
        logic       ey;
        logic [3:0] act;
        logic [3:0] exp_v;
        ycnt = 0;
        for (int i = 0; i < g + r + 1; i++) begin
            @(negedge clock);
            ex    = (i >= g) && (i < g + r);
            ey    = (hist >= 3);
            act   = {busy, done, x_out, expect_y};
            exp_v = {1'b1, 1'b0, ex, ey};
            n_checks++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL %s cycle %0d {busy,done,x,y}: got %b want %b", tag, i + 1, act, exp_v);
            end
            if (expect_y === 1'b1) ycnt++;
            hist = ex ? hist + 1 : 0;
            if (toggle) begin
                start   = 1'($urandom_range(0, 1));
                run_len = 4'($urandom_range(0, 15));
                gap_len = 4'($urandom_range(0, 15));
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clock);
        ey    = (hist >= 3);
        act   = {busy, done, x_out, expect_y};
        exp_v = {1'b0, 1'b1, 1'b0, ey};
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s done cycle {busy,done,x,y}: got %b want %b", tag, act, exp_v);
        end
        hist     = 0;
        exp_ycnt = (r >= 3) ? r - 2 : 0;
        n_checks++;
        if (ycnt != exp_ycnt) begin
            n_fail++;
            $display("FAIL %s expect_y_len: got %0d want %0d", tag, ycnt, exp_ycnt);
        end
        if (chain) begin
            start   = 1'b1;
            gap_len = 4'(ng);
            run_len = 4'(nr);
        end else begin
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [3:0] act;
        #1;
        act = {busy, done, x_out, expect_y};
        n_checks++;
        if (act !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_initial outputs: got %b want 0000", act);
        end
        @(negedge clock);
        reset = 1'b1;
        launch(3, 5);
        repeat (6) @(negedge clock);
        start = 1'b0;
        #2 reset = 1'b0;
        #1;
        act = {busy, done, x_out, expect_y};
        n_checks++;
        if (act !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_async outputs: got %b want 0000", act);
        end
        hist = 0;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            act = {busy, done, x_out, expect_y};
            n_checks++;
            if (act !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_release cycle %0d outputs: got %b want 0000", i, act);
            end
        end
    endtask

    task automatic test_basic();
        launch(2, 3);
        do_seq(2, 3, 1'b0, 1'b0, 0, 0, "gap2_run3");
        launch(0, 2);
        do_seq(0, 2, 1'b0, 1'b0, 0, 0, "gap0_run2");
        launch(0, 0);
        do_seq(0, 0, 1'b0, 1'b0, 0, 0, "gap0_run0");
        launch(4, 0);
        do_seq(4, 0, 1'b0, 1'b0, 0, 0, "gap4_run0");
    endtask

    task automatic test_max_toggle();
        launch(15, 15);
        do_seq(15, 15, 1'b1, 1'b0, 0, 0, "max_toggle");
    endtask

    task automatic test_back_to_back();
        launch(1, 2);
        do_seq(1, 2, 1'b0, 1'b1, 0, 4, "b2b_first");
        do_seq(0, 4, 1'b0, 1'b0, 0, 0, "b2b_second");
    endtask

    task automatic test_reset_mid_run();
        logic [3:0] act;
        logic [3:0] exp_v;
        launch(0, 10);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            exp_v = {1'b1, 1'b0, 1'b1, (hist >= 3)};
            act   = {busy, done, x_out, expect_y};
            n_checks++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL midrun cycle %0d {busy,done,x,y}: got %b want %b", i + 1, act, exp_v);
            end
            hist  = hist + 1;
            start = 1'b0;
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        act = {busy, done, x_out, expect_y};
        n_checks++;
        if (act !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrun_reset outputs: got %b want 0000", act);
        end
        hist = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            act = {busy, done, x_out, expect_y};
            n_checks++;
            if (act !== 4'b0000) begin
                n_fail++;
                $display("FAIL midrun_hold cycle %0d outputs: got %b want 0000", i, act);
            end
        end
        reset = 1'b1;
        @(negedge clock);
        act = {busy, done, x_out, expect_y};
        n_checks++;
        if (act !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrun_no_done outputs: got %b want 0000", act);
        end
        launch(1, 3);
        do_seq(1, 3, 1'b0, 1'b0, 0, 0, "after_midrun");
    endtask

    task automatic test_random();
        int  g;
        int  r;
        int  ng;
        int  nr;
        bit  chain;
        g = $urandom_range(0, 15);
        r = $urandom_range(0, 15);
        launch(g, r);
        for (int i = 0; i < 10; i++) begin
            ng    = $urandom_range(0, 15);
            nr    = $urandom_range(0, 15);
            chain = (i < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
            do_seq(g, r, 1'($urandom_range(0, 1)), chain, ng, nr, "random");
            if (!chain && i < 9) launch(ng, nr);
            g = ng;
            r = nr;
        end
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        run_len = 4'd0;
        gap_len = 4'd0;
        test_reset();
        test_basic();
        test_max_toggle();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ones_run_tx.md
# ones_run_tx

Serial stimulus transmitter for the consecutive-ones detector family. On each accepted request it drives a single-bit stream on `x_out`: a programmable gap of zeros, then a programmable run of ones, then one terminating zero. Alongside the stream it produces `expect_y`, the cycle-exact output a three-ones detector (Moore, output high in its "three or more ones" state) must show when it is fed `x_out` on the same clock. It sits upstream of the detector in lab test harnesses and on-board self-test.

## Interface
- `CNT_W`, default 4: width of `run_len`, `gap_len` and the internal counters. Maximum run and gap are 2^CNT_W−1.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low.
- `start`  in  1  request strobe. Sampled only when `busy`=0.
- `run_len`  in  CNT_W  number of ones to emit. Latched on accept.
- `gap_len`  in  CNT_W  number of leading zeros to emit. Latched on accept.
- `busy`  out  1  high from the first bit of a sequence through its terminating zero.
- `done`  out  1  one-cycle pulse in the cycle after the terminating zero.
- `x_out`  out  1  serial stream, registered. 0 whenever not in RUN.
- `expect_y`  out  1  predicted detector output, registered.

## Operation
- FSM states: IDLE, GAP, RUN, TAIL.
- IDLE:
  - `x_out`=0, `busy`=0.
  - On `start`=1, latch `run_len`/`gap_len` and go to GAP if gap≠0, else RUN if run≠0, else TAIL.
- GAP: `x_out`=0 for exactly `gap_len` cycles, then RUN (run≠0) or TAIL.
- RUN: `x_out`=1 for exactly `run_len` cycles, then TAIL.
- TAIL: `x_out`=0 for one cycle, then IDLE. `done`=1 in the following cycle.
- `busy`=1 in GAP, RUN and TAIL. Busy duration is exactly gap+run+1 cycles.
- `start` while `busy`=1 is ignored. It is neither queued nor latched, and input changes during a sequence have no effect.
- `start` in the `done` cycle (state IDLE) is accepted, so back-to-back sequences are separated only by that one IDLE cycle.
- `expect_y` tracking:
  - A 2-bit saturating counter `ones_cnt` is updated at every edge from the `x_out` value of the ending cycle: 1 → min(cnt+1, 3); 0 → 0.
  - `expect_y` = (`ones_cnt`==3).
  - `ones_cnt` is not cleared between sequences. The TAIL zero clears it naturally.
- Reset (asynchronous, any state, including mid-RUN):
  - state=IDLE, `x_out`=0, `busy`=0, `done`=0, `expect_y`=0, `ones_cnt`=0, latched lengths=0.
  - An interrupted sequence is abandoned, with no `done`.

## Timing
- Reset values: all outputs 0.
- Accept edge E0 (`start`=1, IDLE): the first sequence bit is on `x_out` and `busy`=1 in the cycle after E0. Latency is 1 cycle.
- Run length r: the ones occupy r consecutive cycles.
- For r≥3, `expect_y` is high for r−2 cycles, starting in the cycle after the third one and ending in the TAIL cycle. For r<3 it stays 0.
- `done` coincides with `busy`=0. `expect_y` is 0 in the `done` cycle.
- All outputs change only on the rising edge of `clock` or on assertion of `reset`.

## Test plan
- Reset: assert `reset`=0 mid-simulation → all outputs 0 immediately. Release with `start`=0 → outputs stay 0.
- gap=2, run=3, one `start` pulse:
  - `x_out` = 0,0,1,1,1,0 over 6 cycles, `busy` high for those 6 cycles.
  - `expect_y` high only in cycle 6; `done` high in cycle 7.
- gap=0, run=2: `x_out` = 1,1,0, `expect_y` never high, `done` in cycle 4. Separately, gap=0, run=0: a single TAIL zero, `busy` 1 cycle, `done` next cycle.
- gap=15, run=15:
  - `busy` high for 31 cycles and `expect_y` high for 13 consecutive cycles.
  - Toggling `start`, `run_len` and `gap_len` during the sequence changes nothing.
- Back-to-back: assert `start` in the `done` cycle with run=4 → the next sequence starts the following cycle, and `expect_y` is high for 2 cycles.
- Reset mid-RUN (run=10, reset asserted at the 5th one) → `x_out`/`busy`/`expect_y` go 0 at once, no `done` pulse, and a new `start` after release behaves normally.
